// File: rtl/coeff_token_ctrl_if.sv
// coeff_token_ctrl_if
//   Bundles the descriptor input handshake, the shared VLC ROM address/data
//   path and the token output handshake of coeff_token_ctrl.
//   master : environment side (block scanner, coeff_token ROMs, packer)
//   slave  : controller side (coeff_token_ctrl)
//   Signals:
//     in_valid/in_ready          descriptor handshake
//     total_coeff, trailing_ones descriptor fields
//     n_a, n_b, avail_a, avail_b neighbour non-zero counts and availability
//     tbl_addr                   shared address {T1s, TotalCoeff} to the ROMs
//     tbl_code0..2               combinational VLC0/VLC1/VLC2 ROM words
//     tok_valid/tok_ready        token handshake to the packer
//     tok_bits, tok_len, tok_err token payload
//     tok_count                  tokens accepted by the packer (wrapping)
interface coeff_token_ctrl_if #(
    parameter int unsigned aWIDTH  = 7,
    parameter int unsigned vcWIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         total_coeff;
    logic [1:0]         trailing_ones;
    logic [4:0]         n_a;
    logic [4:0]         n_b;
    logic               avail_a;
    logic               avail_b;
    logic [aWIDTH-1:0]  tbl_addr;
    logic [vcWIDTH-1:0] tbl_code0;
    logic [vcWIDTH-1:0] tbl_code1;
    logic [vcWIDTH-1:0] tbl_code2;
    logic               tok_valid;
    logic               tok_ready;
    logic [15:0]        tok_bits;
    logic [4:0]         tok_len;
    logic               tok_err;
    logic [15:0]        tok_count;

    modport master (
        output in_valid, total_coeff, trailing_ones, n_a, n_b, avail_a, avail_b,
        output tbl_code0, tbl_code1, tbl_code2, tok_ready,
        input  in_ready, tbl_addr, tok_valid, tok_bits, tok_len, tok_err, tok_count
    );

    modport slave (
        input  in_valid, total_coeff, trailing_ones, n_a, n_b, avail_a, avail_b,
        input  tbl_code0, tbl_code1, tbl_code2, tok_ready,
        output in_ready, tbl_addr, tok_valid, tok_bits, tok_len, tok_err, tok_count
    );
endinterface

// File: rtl/coeff_token_ctrl.sv
// coeff_token_ctrl
//   Sequencing controller for CAVLC coeff_token encoding. Accepts one 4x4
//   block descriptor, derives nC from the neighbour counts, picks VLC0/1/2 or
//   the 6-bit FLC, addresses the shared coeff_token ROMs and hands a
//   right-aligned codeword plus its length to the bitstream packer.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  coeff_token_ctrl_if.slave (descriptor in, ROM address/data, token out)
//   Sequence: IDLE -> CALC -> LOOK -> OUT -> IDLE, one token per 4 cycles.
module coeff_token_ctrl #(
    parameter int unsigned aWIDTH  = 7,
    parameter int unsigned vcWIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    coeff_token_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        LOOK,
        OUT
    } state_t;

    typedef enum logic [1:0] {
        SEL_VLC0,
        SEL_VLC1,
        SEL_VLC2,
        SEL_FLC
    } sel_t;

    state_t             state_q, state_d;
    sel_t               sel_q, sel_d;
    logic [4:0]         tc_q, tc_d;
    logic [1:0]         t1_q, t1_d;
    logic [4:0]         na_q, na_d;
    logic [4:0]         nb_q, nb_d;
    logic               ava_q, ava_d;
    logic               avb_q, avb_d;
    logic               err_q, err_d;
    logic [aWIDTH-1:0]  addr_q, addr_d;
    logic [15:0]        bits_q, bits_d;
    logic [4:0]         len_q, len_d;
    logic               terr_q, terr_d;
    logic [15:0]        count_q, count_d;

    logic [5:0]         nc_sum;
    logic [4:0]         nc;
    sel_t               sel_calc;
    logic               illegal;
    logic [vcWIDTH-1:0] code_sel;

    // nC, table selection, legality and ROM word mux, all from registered
    // descriptor fields so they are stable for the whole CALC/LOOK window.
    always_comb begin
        // 6-bit sum: 31+31+1 cannot overflow before the halving.
        nc_sum = {1'b0, na_q} + {1'b0, nb_q} + 6'd1;
        case ({ava_q, avb_q})
            2'b11:   nc = 5'(nc_sum >> 1);
            2'b10:   nc = na_q;
            2'b01:   nc = nb_q;
            default: nc = '0;
        endcase

        if (nc < 5'd2) begin
            sel_calc = SEL_VLC0;
        end else if (nc < 5'd4) begin
            sel_calc = SEL_VLC1;
        end else if (nc < 5'd8) begin
            sel_calc = SEL_VLC2;
        end else begin
            sel_calc = SEL_FLC;
        end

        illegal = (tc_q > 5'd16) || ({3'b000, t1_q} > tc_q);

        case (sel_q)
            SEL_VLC0: code_sel = bus.tbl_code0;
            SEL_VLC1: code_sel = bus.tbl_code1;
            SEL_VLC2: code_sel = bus.tbl_code2;
            default:  code_sel = '0;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tc_d    = tc_q;
        t1_d    = t1_q;
        na_d    = na_q;
        nb_d    = nb_q;
        ava_d   = ava_q;
        avb_d   = avb_q;
        err_d   = err_q;
        addr_d  = addr_q;
        bits_d  = bits_q;
        len_d   = len_q;
        terr_d  = terr_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    tc_d    = bus.total_coeff;
                    t1_d    = bus.trailing_ones;
                    na_d    = bus.n_a;
                    nb_d    = bus.n_b;
                    ava_d   = bus.avail_a;
                    avb_d   = bus.avail_b;
                    // Address is captured with the descriptor so the ROMs
                    // already see it throughout CALC and LOOK.
                    addr_d  = aWIDTH'({bus.trailing_ones, bus.total_coeff});
                    state_d = CALC;
                end
            end

            CALC: begin
                sel_d   = sel_calc;
                err_d   = illegal;
                state_d = LOOK;
            end

            LOOK: begin
                if (err_q) begin
                    bits_d = '0;
                    len_d  = '0;
                    terr_d = 1'b1;
                end else if (sel_q == SEL_FLC) begin
                    len_d  = 5'd6;
                    terr_d = 1'b0;
                    if (tc_q == 5'd0) begin
                        bits_d = 16'h0003;
                    end else begin
                        bits_d = {10'b0, 4'(tc_q - 5'd1), t1_q};
                    end
                end else if (code_sel == '0) begin
                    // An all-zero ROM word marks a hole in the table.
                    err_d  = 1'b1;
                    bits_d = '0;
                    len_d  = '0;
                    terr_d = 1'b1;
                end else begin
                    bits_d = {12'b0, code_sel[3:0]};
                    len_d  = {1'b0, code_sel[7:4]} + 5'd1;
                    terr_d = 1'b0;
                end
                state_d = OUT;
            end

            OUT: begin
                if (bus.tok_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_VLC0;
            tc_q    <= '0;
            t1_q    <= '0;
            na_q    <= '0;
            nb_q    <= '0;
            ava_q   <= 1'b0;
            avb_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            bits_q  <= '0;
            len_q   <= '0;
            terr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tc_q    <= tc_d;
            t1_q    <= t1_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            ava_q   <= ava_d;
            avb_q   <= avb_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            bits_q  <= bits_d;
            len_q   <= len_d;
            terr_q  <= terr_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.tok_valid = (state_q == OUT);
    assign bus.tbl_addr  = addr_q;
    assign bus.tok_bits  = bits_q;
    assign bus.tok_len   = len_q;
    assign bus.tok_err   = terr_q;
    assign bus.tok_count = count_q;

endmodule
